msg_scroll_disp: RTL and testbench

- Parametrised successor to the fixed two-character seven-segment greeter.
- Holds a writable message buffer of MSG_LEN segment patterns and shows a DIGITS-wide window of it on a multiplexed display.
- A built-in debouncer turns the user button into mode steps: static, scrolling, paused, blank.
- Sits between the board button/bus and the seven-segment pins, replacing the separate debouncer and display mux in top-level use.

---
 rtl/msg_scroll_disp.sv | 179 +++++++++++++++++
 tb/tb_msg_scroll_disp.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroll_disp.sv
// Scrolling seven-segment message display with a built-in button debouncer.
// Optional build macro PAUSE_BLINK_EN: blink the frozen window while paused.
module msg_scroll_disp #(
   parameter int DIGITS      = 4,
   parameter int MSG_LEN     = 8,
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 25000000,
   parameter int DB_CYCLES   = 1000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       button,
   input  logic                       msg_wr,
   input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
   input  logic [7:0]                 msg_data,
   output logic [DIGITS-1:0]          an,
   output logic [7:0]                 sseg,
   output logic [1:0]                 mode,
   output logic [$clog2(MSG_LEN)-1:0] pos
);

   localparam int AW = $clog2(MSG_LEN);
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int BW = $clog2(DB_CYCLES + 1);

   localparam logic [1:0] ST_STATIC = 2'b00;
   localparam logic [1:0] ST_SCROLL = 2'b01;
   localparam logic [1:0] ST_PAUSE  = 2'b10;
   localparam logic [1:0] ST_BLANK  = 2'b11;

   localparam logic [AW:0]   MSG_N   = (AW+1)'(MSG_LEN);
   localparam logic [AW-1:0] P_LAST  = AW'(MSG_LEN - 1);
   localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);
   localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] S_LAST  = SW'(SCROLL_DIV - 1);
   localparam logic [BW-1:0] DB_MAX  = BW'(DB_CYCLES);
   localparam logic [BW-1:0] DB_LAST = BW'(DB_CYCLES - 1);

   logic [1:0]          r_sync;
   logic [BW-1:0]       r_db_cnt;
   logic                r_db_tick;
   logic [1:0]          r_mode;
   logic [AW-1:0]       r_pos;
   logic [SW-1:0]       r_scnt;
   logic [RW-1:0]       r_ref;
   logic [DW-1:0]       r_dig;
   logic [DIGITS-1:0]   r_an;
   logic [7:0]          r_sseg;
   logic [7:0]          r_msg [MSG_LEN];

   logic                w_scnt_term;
   logic                w_hide;
   logic [AW:0]         w_sum;
   logic [AW:0]         w_idx;

   assign w_scnt_term = (r_scnt == S_LAST);
   assign w_sum       = {1'b0, r_pos} + (AW+1)'(r_dig);
   assign w_idx       = (w_sum >= MSG_N) ? (w_sum - MSG_N) : w_sum;

`ifdef PAUSE_BLINK_EN
   logic r_blink;
   assign w_hide = (r_mode == ST_PAUSE) && r_blink;
`else
   assign w_hide = 1'b0;
`endif

   // Counter saturates at DB_CYCLES so a held button yields a single tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync    <= '0;
         r_db_cnt  <= '0;
         r_db_tick <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], button};
         r_db_tick <= r_sync[1] && (r_db_cnt == DB_LAST);
         if (!r_sync[1])
            r_db_cnt <= '0;
         else if (r_db_cnt != DB_MAX)
            r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   // A debounced press coinciding with the scroll terminal count discards the step.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= ST_STATIC;
         r_pos  <= '0;
         r_scnt <= '0;
`ifdef PAUSE_BLINK_EN
         r_blink <= 1'b0;
`endif
      end else begin
         case (r_mode)
            ST_STATIC: begin
               r_pos  <= '0;
               r_scnt <= '0;
            end
            ST_SCROLL: begin
               if (en) begin
                  if (w_scnt_term) begin
                     r_scnt <= '0;
                     if (!r_db_tick)
                        r_pos <= (r_pos == P_LAST) ? '0 : r_pos + 1'b1;
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
`ifdef PAUSE_BLINK_EN
            ST_PAUSE: begin
               if (en) begin
                  if (w_scnt_term) begin
                     r_scnt  <= '0;
                     r_blink <= ~r_blink;
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
`endif
            default: ;
         endcase
         if (r_db_tick) begin
            r_mode <= r_mode + 2'd1;
            if (r_mode == ST_BLANK)
               r_pos <= '0;
`ifdef PAUSE_BLINK_EN
            r_blink <= 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ref  <= '0;
         r_dig  <= '0;
         r_an   <= '1;
         r_sseg <= 8'hFF;
      end else if (!en || (r_mode == ST_BLANK)) begin
         r_an   <= '1;
         r_sseg <= 8'hFF;
      end else begin
         if (r_ref == R_LAST) begin
            r_ref <= '0;
            r_dig <= (r_dig == D_LAST) ? '0 : r_dig + 1'b1;
         end else begin
            r_ref <= r_ref + 1'b1;
         end
         if (w_hide) begin
            r_an   <= '1;
            r_sseg <= 8'hFF;
         end else begin
            r_an   <= ~(DIGITS'(1) << r_dig);
            r_sseg <= r_msg[w_idx[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < MSG_LEN; i++)
            r_msg[i] <= 8'hFF;
         r_msg[0] <= 8'hF9;
         r_msg[1] <= 8'h89;
      end else if (msg_wr && ({1'b0, msg_addr} < MSG_N)) begin
         r_msg[msg_addr] <= msg_data;
      end
   end

   assign an   = r_an;
   assign sseg = r_sseg;
   assign mode = r_mode;
   assign pos  = r_pos;

endmodule

// File: tb/tb_msg_scroll_disp.sv
// Self-checking bench for msg_scroll_disp: directed scenarios plus random
// stimulus compared against a behavioural model of the display rules.
module tb_msg_scroll_disp;

   localparam int DG = 4;
   localparam int ML = 8;
   localparam int RD = 4;
   localparam int SD = 16;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       button = 1'b0;
   logic       msg_wr = 1'b0;
   logic [2:0] msg_addr = '0;
   logic [7:0] msg_data = '0;
   logic [3:0] an;
   logic [7:0] sseg;
   logic [1:0] mode;
   logic [2:0] pos;

   logic       en6 = 1'b1;
   logic       button6 = 1'b0;
   logic       msg_wr6 = 1'b0;
   logic [2:0] msg_addr6 = '0;
   logic [7:0] msg_data6 = '0;
   logic [3:0] an6;
   logic [7:0] sseg6;
   logic [1:0] mode6;
   logic [2:0] pos6;

   int n_chk = 0;
   int n_pass = 0;

   // Behavioural model state
   int         m_mode, m_pos, m_scnt, m_ref, m_dig, m_run;
   int         m_hist [3];
   logic [7:0] m_msg [ML];
   logic [3:0] m_an;
   logic [7:0] m_sseg;

   msg_scroll_disp #(.DIGITS(DG), .MSG_LEN(ML), .REFRESH_DIV(RD),
                     .SCROLL_DIV(SD), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .en(en), .button(button), .msg_wr(msg_wr),
      .msg_addr(msg_addr), .msg_data(msg_data), .an(an), .sseg(sseg),
      .mode(mode), .pos(pos));

   msg_scroll_disp #(.DIGITS(DG), .MSG_LEN(6), .REFRESH_DIV(RD),
                     .SCROLL_DIV(SD), .DB_CYCLES(DB)) dut6 (
      .clk(clk), .reset(reset), .en(en6), .button(button6), .msg_wr(msg_wr6),
      .msg_addr(msg_addr6), .msg_data(msg_data6), .an(an6), .sseg(sseg6),
      .mode(mode6), .pos(pos6));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // A press is seen by the mode logic 3 edges after the button has been
   // high for exactly DB consecutive samples (2-flop sync + registered tick).
   function automatic void model_step();
      bit tick;
      if (reset) begin
         m_mode = 0; m_pos = 0; m_scnt = 0; m_ref = 0; m_dig = 0; m_run = 0;
         m_hist = '{0, 0, 0};
         foreach (m_msg[i]) m_msg[i] = 8'hFF;
         m_msg[0] = 8'hF9;
         m_msg[1] = 8'h89;
         m_an = 4'hF;
         m_sseg = 8'hFF;
         return;
      end
      tick = (m_hist[2] == DB);
      if (!en || m_mode == 3) begin
         m_an = 4'hF;
         m_sseg = 8'hFF;
      end else begin
         m_an = ~(4'b0001 << m_dig);
         m_sseg = m_msg[(m_pos + m_dig) % ML];
         m_ref = (m_ref + 1) % RD;
         if (m_ref == 0) m_dig = (m_dig + 1) % DG;
      end
      if (m_mode == 0) begin
         m_pos = 0;
         m_scnt = 0;
      end else if (m_mode == 1 && en) begin
         if (m_scnt == SD - 1) begin
            m_scnt = 0;
            if (!tick) m_pos = (m_pos + 1) % ML;
         end else begin
            m_scnt++;
         end
      end
      if (tick) begin
         m_mode = (m_mode + 1) % 4;
         if (m_mode == 0) m_pos = 0;
      end
      if (msg_wr && int'(msg_addr) < ML) m_msg[msg_addr] = msg_data;
      m_run = button ? ((m_run < DB + 1) ? m_run + 1 : m_run) : 0;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = m_run;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic press();
      button = 1'b1;
      repeat (5) cycle();
      button = 1'b0;
      repeat (6) cycle();
   endtask

   task automatic test_reset();
      logic [3:0] exp_an [4];
      logic [7:0] exp_seg [4];
      exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
      exp_seg = '{8'hF9, 8'h89, 8'hFF, 8'hFF};
      button = 1'b0; msg_wr = 1'b0; en = 1'b1; reset = 1'b1;
      cycle(); cycle();
      n_chk++;
      if ({an, sseg, mode, pos} !== {4'hF, 8'hFF, 2'b00, 3'd0})
         $display("FAIL reset_state: got an=%h sseg=%h mode=%0d pos=%0d want an=f sseg=ff mode=0 pos=0",
                  an, sseg, mode, pos);
      else n_pass++;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         n_chk++;
         if (an !== exp_an[i/4] || sseg !== exp_seg[i/4])
            $display("FAIL reset_scan[%0d]: got an=%h sseg=%h want an=%h sseg=%h",
                     i, an, sseg, exp_an[i/4], exp_seg[i/4]);
         else n_pass++;
      end
      n_chk++;
      if (mode !== 2'b00 || pos !== 3'd0)
         $display("FAIL reset_mode: got mode=%0d pos=%0d want 0 0", mode, pos);
      else n_pass++;
   endtask

   task automatic test_mode_step();
      button = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         cycle();
         n_chk++;
         if (mode !== ((i == 6) ? 2'b01 : 2'b00))
            $display("FAIL step_latency[%0d]: got mode=%0d want %0d", i, mode, (i == 6) ? 1 : 0);
         else n_pass++;
      end
      button = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (i == 15) begin
            n_chk++;
            if (pos !== 3'd0) $display("FAIL scroll_early: got pos=%0d want 0", pos);
            else n_pass++;
         end
      end
      n_chk++;
      if (pos !== 3'd1) $display("FAIL scroll_first: got pos=%0d want 1", pos);
      else n_pass++;
      for (int i = 1; i <= 112; i++) begin
         cycle();
         if (i == 96) begin
            n_chk++;
            if (pos !== 3'd7) $display("FAIL scroll_last: got pos=%0d want 7", pos);
            else n_pass++;
         end
      end
      n_chk++;
      if (pos !== 3'd0 || mode !== 2'b01)
         $display("FAIL scroll_wrap: got pos=%0d mode=%0d want 0 1", pos, mode);
      else n_pass++;
   endtask

   task automatic test_debounce();
      logic [1:0] prev;
      int changes;
      logic pat [5];
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      prev = mode; changes = 0;
      for (int i = 0; i < 13; i++) begin
         button = (i < 5) ? pat[i] : 1'b0;
         cycle();
         if (mode !== prev) changes++;
         prev = mode;
      end
      n_chk++;
      if (changes != 0 || mode !== 2'b01)
         $display("FAIL glitch_reject: got changes=%0d mode=%0d want 0 1", changes, mode);
      else n_pass++;
      foreach (m_hist[k]) if (k < 0) $display("unused");
      changes = 0;
      button = 1'b1;
      repeat (5) begin cycle(); if (mode !== prev) changes++; prev = mode; end
      button = 1'b0;
      repeat (10) begin cycle(); if (mode !== prev) changes++; prev = mode; end
      n_chk++;
      if (changes != 1 || mode !== 2'b10)
         $display("FAIL hold5_one_step: got changes=%0d mode=%0d want 1 2", changes, mode);
      else n_pass++;
      changes = 0;
      button = 1'b1;
      repeat (40) begin cycle(); if (mode !== prev) changes++; prev = mode; end
      button = 1'b0;
      repeat (10) begin cycle(); if (mode !== prev) changes++; prev = mode; end
      n_chk++;
      if (changes != 1 || mode !== 2'b11)
         $display("FAIL hold40_one_step: got changes=%0d mode=%0d want 1 3", changes, mode);
      else n_pass++;
      press();
      n_chk++;
      if (mode !== 2'b00 || pos !== 3'd0)
         $display("FAIL blank_to_static: got mode=%0d pos=%0d want 0 0", mode, pos);
      else n_pass++;
      press();
      n_chk++;
      if (mode !== 2'b01) $display("FAIL static_to_scroll: got mode=%0d want 1", mode);
      else n_pass++;
   endtask

   task automatic test_coincide();
      int guard;
      int p0;
      guard = 0;
      while (m_scnt != SD - 6 && guard < 64) begin cycle(); guard++; end
      if (guard == 64) begin
         n_chk++;
         $display("FAIL coincide_align: got timeout want scroll count %0d", SD - 6);
      end
      p0 = m_pos;
      n_chk++;
      if (mode !== 2'b01 || pos !== 3'(p0))
         $display("FAIL coincide_pre: got mode=%0d pos=%0d want 1 %0d", mode, pos, p0);
      else n_pass++;
      button = 1'b1;
      repeat (5) cycle();
      button = 1'b0;
      cycle();
      n_chk++;
      if (mode !== 2'b10 || pos !== 3'(p0))
         $display("FAIL coincide_step: got mode=%0d pos=%0d want 2 %0d", mode, pos, p0);
      else n_pass++;
      press();
      n_chk++;
      if (mode !== 2'b11 || an !== 4'hF || sseg !== 8'hFF)
         $display("FAIL blank_out: got mode=%0d an=%h sseg=%h want 3 f ff", mode, an, sseg);
      else n_pass++;
      press();
      n_chk++;
      if (mode !== 2'b00 || pos !== 3'd0)
         $display("FAIL back_static: got mode=%0d pos=%0d want 0 0", mode, pos);
      else n_pass++;
   endtask

   task automatic test_write();
      bit found;
      msg_wr = 1'b1; msg_addr = 3'd2; msg_data = 8'hC0;
      cycle();
      msg_wr = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 32 && !found; i++) begin
         cycle();
         if (an === 4'hB) begin
            found = 1'b1;
            n_chk++;
            if (sseg !== 8'hC0) $display("FAIL write_visible: got sseg=%h want c0", sseg);
            else n_pass++;
         end
      end
      if (!found) begin
         n_chk++;
         $display("FAIL write_slot: got no digit-2 drive within 32 cycles want an=b");
      end
   endtask

   task automatic test_range();
      logic [7:0] exp6 [4];
      exp6 = '{8'hF9, 8'h89, 8'hFF, 8'hA4};
      msg_wr6 = 1'b1;
      msg_addr6 = 3'd6; msg_data6 = 8'h00; cycle();
      msg_addr6 = 3'd7; msg_data6 = 8'h00; cycle();
      msg_addr6 = 3'd3; msg_data6 = 8'hA4; cycle();
      msg_wr6 = 1'b0;
      cycle();
      for (int i = 0; i < 16; i++) begin
         int k;
         cycle();
         case (an6)
            4'hE: k = 0;
            4'hD: k = 1;
            4'hB: k = 2;
            4'h7: k = 3;
            default: k = -1;
         endcase
         n_chk++;
         if (k < 0) $display("FAIL range_anode[%0d]: got an=%h want one-hot low", i, an6);
         else if (sseg6 !== exp6[k])
            $display("FAIL range_buffer[%0d]: got digit%0d sseg=%h want %h", i, k, sseg6, exp6[k]);
         else n_pass++;
      end
   endtask

   task automatic test_en();
      int p0, held;
      press();
      repeat (7) cycle();
      p0 = m_pos;
      held = m_dig;
      en = 1'b0;
      repeat (50) begin
         cycle();
         n_chk++;
         if (an !== 4'hF || sseg !== 8'hFF || pos !== 3'(p0))
            $display("FAIL en_low: got an=%h sseg=%h pos=%0d want f ff %0d", an, sseg, pos, p0);
         else n_pass++;
      end
      en = 1'b1;
      cycle();
      n_chk++;
      if (an !== ~(4'b0001 << held))
         $display("FAIL en_resume_digit: got an=%h want %h", an, ~(4'b0001 << held));
      else n_pass++;
      repeat (40) begin
         cycle();
         n_chk++;
         if ({an, sseg, mode, pos} !== {m_an, m_sseg, 2'(m_mode), 3'(m_pos)})
            $display("FAIL en_resume: got an=%h sseg=%h mode=%0d pos=%0d want %h %h %0d %0d",
                     an, sseg, mode, pos, m_an, m_sseg, m_mode, m_pos);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            button = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 9));
         end
         hold--;
         if (en) begin
            if ($urandom_range(0, 49) == 0) en = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            en = 1'b1;
         end
         msg_wr   = ($urandom_range(0, 9) == 0);
         msg_addr = 3'($urandom_range(0, 7));
         msg_data = 8'($urandom);
         cycle();
         n_chk++;
         if ({an, sseg, mode, pos} !== {m_an, m_sseg, 2'(m_mode), 3'(m_pos)})
            $display("FAIL random[%0d]: got an=%h sseg=%h mode=%0d pos=%0d want %h %h %0d %0d",
                     i, an, sseg, mode, pos, m_an, m_sseg, m_mode, m_pos);
         else n_pass++;
      end
      msg_wr = 1'b0; en = 1'b1; button = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mode_step();
      test_debounce();
      test_coincide();
      test_write();
      test_range();
      test_en();
      test_random();
      test_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
